// File: rtl/cfg_loader.sv
// Byte-serial configuration loader: assembles per-block cfg words in a shadow
// register and commits them atomically onto cfg_out. Optional checksum: CFG_LOADER_CRC_EN.
module cfg_loader #(
    parameter int          NUM_BLOCKS = 4,
    parameter int          CFG_SIZE   = 10,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    localparam int         TOTAL      = NUM_BLOCKS * CFG_SIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [TOTAL-1:0] cfg_out,
    output logic             cfg_valid,
    output logic             busy,
    output logic             err
);

    localparam int NBYTES = (TOTAL + 7) / 8;
    // One extra count value so the counter parks at NBYTES instead of wrapping.
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
`ifdef CFG_LOADER_CRC_EN
    localparam logic [1:0] ST_CHECK  = 2'd2;
`endif
    localparam logic [1:0] ST_COMMIT = 2'd3;

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [TOTAL-1:0] shadow_q,    shadow_d;
    logic [TOTAL-1:0] cfg_out_q,   cfg_out_d;
    logic             cfg_valid_q, cfg_valid_d;
`ifdef CFG_LOADER_CRC_EN
    logic             err_q,       err_d;
    logic [7:0]       csum_q,      csum_d;
`endif
    logic             accept;

    assign in_ready  = (state_q != ST_COMMIT);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != ST_IDLE);
    assign cfg_out   = cfg_out_q;
    assign cfg_valid = cfg_valid_q;
`ifdef CFG_LOADER_CRC_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        cfg_out_d   = cfg_out_q;
        cfg_valid_d = cfg_valid_q;
`ifdef CFG_LOADER_CRC_EN
        err_d       = err_q;
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept && in_data == SYNC_BYTE) begin
                    state_d     = ST_LOAD;
                    cnt_d       = '0;
                    cfg_valid_d = 1'b0;
`ifdef CFG_LOADER_CRC_EN
                    err_d       = 1'b0;
                    csum_d      = 8'h00;
`endif
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    // Padding bits of the last byte have no shadow bit to land in.
                    for (int b = 0; b < TOTAL; b++) begin
                        if (cnt_q == CNT_W'(b / 8)) begin
                            shadow_d[b] = in_data[b % 8];
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
`ifdef CFG_LOADER_CRC_EN
                    csum_d = csum_q ^ in_data;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_CHECK;
                    end
`else
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_COMMIT;
                    end
`endif
                end
            end
`ifdef CFG_LOADER_CRC_EN
            ST_CHECK: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = ST_COMMIT;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            ST_COMMIT: begin
                cfg_out_d   = shadow_q;
                cfg_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            cfg_out_q   <= '0;
            cfg_valid_q <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
            err_q       <= 1'b0;
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            cfg_out_q   <= cfg_out_d;
            cfg_valid_q <= cfg_valid_d;
`ifdef CFG_LOADER_CRC_EN
            err_q       <= err_d;
            csum_q      <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_cfg_loader.sv
// Randomized bench for cfg_loader, compared every cycle against a transaction-level
// reference model that works on a queue of received bytes.
module tb_cfg_loader;

    localparam int          NUM_BLOCKS = 4;
    localparam int          CFG_SIZE   = 10;
    localparam int          TOTAL      = NUM_BLOCKS * CFG_SIZE;
    localparam int          NBYTES     = (TOTAL + 7) / 8;
    localparam logic [7:0]  SYNC       = 8'hA5;
`ifdef CFG_LOADER_CRC_EN
    localparam bit          CRC_EN     = 1'b1;
`else
    localparam bit          CRC_EN     = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [TOTAL-1:0] cfg_out;
    logic             cfg_valid;
    logic             busy;
    logic             err;

    always #5 clk = ~clk;

    cfg_loader #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .CFG_SIZE   (CFG_SIZE),
        .SYNC_BYTE  (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cfg_out   (cfg_out),
        .cfg_valid (cfg_valid),
        .busy      (busy),
        .err       (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: "loading" = sync seen and bytes still expected,
    // "pending" = the single commit cycle is owed.
    bit               m_loading;
    bit               m_pending;
    bit               m_valid;
    bit               m_err;
    logic [TOTAL-1:0] m_cfg;
    logic [7:0]       m_bytes[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [TOTAL-1:0] assemble();
        logic [TOTAL-1:0] r;
        r = '0;
        for (int i = 0; i < NBYTES; i++)
            for (int j = 0; j < 8; j++)
                if (8 * i + j < TOTAL) r[8 * i + j] = m_bytes[i][j];
        return r;
    endfunction

    function automatic logic [7:0] xor_bytes(input logic [8*NBYTES-1:0] v);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < NBYTES; i++) x ^= v[8 * i +: 8];
        return x;
    endfunction

    task automatic model_accept(input logic [7:0] d);
        logic [7:0] x;
        if (!m_loading) begin
            if (d == SYNC) begin
                m_loading = 1'b1;
                m_bytes.delete();
                m_valid   = 1'b0;
                m_err     = 1'b0;
            end
        end else if (m_bytes.size() < NBYTES) begin
            m_bytes.push_back(d);
            if (m_bytes.size() == NBYTES && !CRC_EN) begin
                m_loading = 1'b0;
                m_pending = 1'b1;
            end
        end else begin
            x = 8'h00;
            foreach (m_bytes[i]) x ^= m_bytes[i];
            m_loading = 1'b0;
            if (d == x) m_pending = 1'b1;
            else        m_err     = 1'b1;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
    task automatic cycle(input bit r, input bit v, input logic [7:0] d, output bit acc);
        rst      = r;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        acc = 1'b0;
        if (r) begin
            m_loading = 0; m_pending = 0; m_valid = 0; m_err = 0; m_cfg = '0;
            m_bytes.delete();
        end else if (m_pending) begin
            m_cfg     = assemble();
            m_valid   = 1'b1;
            m_pending = 1'b0;
            $display("load committed: cfg_out=%h", m_cfg);
        end else if (v) begin
            acc = 1'b1;
            model_accept(d);
        end
        @(negedge clk);
        check("cfg_out",   64'(cfg_out), 64'(m_cfg));
        check("cfg_valid", 64'(cfg_valid), 64'(m_valid));
        check("busy",      64'(busy), 64'(m_loading || m_pending));
        check("in_ready",  64'(in_ready), 64'(!m_pending));
        check("err",       64'(err), 64'(m_err));
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cycle(1'b0, 1'b0, 8'h00, acc);
    endtask

    task automatic send(input logic [7:0] d, input int maxgap);
        bit acc;
        idle($urandom_range(maxgap, 0));
        acc = 1'b0;
        for (int t = 0; t < 4 && !acc; t++) cycle(1'b0, 1'b1, d, acc);
        check("byte_accepted", 64'(acc), 64'd1);
    endtask

    task automatic load(input logic [8*NBYTES-1:0] v, input int maxgap, input bit good_crc);
        send(SYNC, maxgap);
        for (int i = 0; i < NBYTES; i++) send(v[8 * i +: 8], maxgap);
        if (CRC_EN) send(xor_bytes(v) ^ (good_crc ? 8'h00 : 8'h01), maxgap);
    endtask

    initial begin
        logic [8*NBYTES-1:0] v;
        bit acc;
        m_loading = 0; m_pending = 0; m_valid = 0; m_err = 0; m_cfg = '0;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) cycle(1'b1, 1'b0, 8'h00, acc);

        // Back-to-back load
        load(40'h0504030201, 0, 1'b1);
        idle(2);
        check("t1_cfg", 64'(cfg_out), 64'h0504030201);
        check("t1_valid", 64'(cfg_valid), 64'd1);

        // Leading junk before the sync byte
        send(8'h00, 0); send(8'hFF, 0); send(8'h5A, 0);
        load(40'h0504030201, 0, 1'b1);
        idle(2);
        check("t2_cfg", 64'(cfg_out), 64'h0504030201);

        // Gaps during the load
        load(40'h0504030201, 4, 1'b1);
        idle(2);
        check("t3_cfg", 64'(cfg_out), 64'h0504030201);

        // Reset mid-load, then a fresh load
        send(SYNC, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
        cycle(1'b1, 1'b0, 8'h00, acc);
        check("t4_cfg_rst", 64'(cfg_out), 64'd0);
        load(40'h1122334455, 2, 1'b1);
        idle(2);
        check("t4_cfg", 64'(cfg_out), 64'h1122334455);

        // Reload over an existing config
        load(40'h0504030201, 0, 1'b1);
        idle(1);
        load(40'hFFFFFFFFFF, 1, 1'b1);
        idle(2);
        check("t5_cfg", 64'(cfg_out), 64'hFFFFFFFFFF);

        if (CRC_EN) begin
            load(40'h0504030201, 0, 1'b1);
            idle(2);
            check("t6_cfg", 64'(cfg_out), 64'h0504030201);
            load(40'hFFFFFFFF00, 0, 1'b0);
            idle(2);
            check("t6_err", 64'(err), 64'd1);
            check("t6_cfg_hold", 64'(cfg_out), 64'h0504030201);
            check("t6_valid", 64'(cfg_valid), 64'd0);
            send(SYNC, 0);
            check("t6_err_clr", 64'(err), 64'd0);
            idle(1);
        end

        // Random structured loads with junk, gaps, bad checksums and resets
        for (int n = 0; n < 150; n++) begin
            for (int k = $urandom_range(2, 0); k > 0; k--) send(8'($urandom_range(255, 0)), 2);
            send(SYNC, 3);
            for (int i = 0; i < NBYTES; i++) begin
                v[8 * i +: 8] = ($urandom_range(7, 0) == 0) ? SYNC : 8'($urandom_range(255, 0));
                send(v[8 * i +: 8], 3);
                if ($urandom_range(40, 0) == 0) cycle(1'b1, 1'b0, 8'h00, acc);
            end
            if (CRC_EN) send(xor_bytes(v) ^ (($urandom_range(3, 0) == 0) ? 8'h10 : 8'h00), 3);
            idle($urandom_range(2, 0));
        end

        // Unstructured random traffic
        for (int c = 0; c < 1500; c++) begin
            cycle($urandom_range(199, 0) == 0, $urandom_range(1, 0) == 1,
                  ($urandom_range(3, 0) == 0) ? SYNC : 8'($urandom_range(255, 0)), acc);
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
